// File: rtl/mixer_iq_scaled.sv
// Quadrature mixer: multiplies real or complex samples by an NCO cos/sin pair,
// then scales by a per-sample arithmetic right shift with rounding and
// saturation. Four-stage pipeline, one sample per clock, no backpressure.
//
// Optional feature: define MIXER_IQ_DITHER_EN to replace the round-half-up
// constant with LFSR dither (16-bit Fibonacci, taps 16,14,13,11).
module mixer_iq_scaled #(
   parameter int unsigned DATA_WIDTH  = 12,
   parameter int unsigned LO_WIDTH    = 12,
   parameter int unsigned OUT_WIDTH   = 16,
   parameter int unsigned SHIFT_WIDTH = 5
) (
   input  logic                          clock,
   input  logic                          clock_sreset,
   input  logic                          in_valid,
   input  logic signed [DATA_WIDTH-1:0]  data_i,
   input  logic signed [DATA_WIDTH-1:0]  data_q,
   input  logic signed [LO_WIDTH-1:0]    cosine_in,
   input  logic signed [LO_WIDTH-1:0]    sine_in,
   input  logic                          complex_mode,
   input  logic        [SHIFT_WIDTH-1:0] shift,
   input  logic                          ovf_clear,
   output logic                          out_valid,
   output logic signed [OUT_WIDTH-1:0]   i_out,
   output logic signed [OUT_WIDTH-1:0]   q_out,
   output logic                          ovf_sticky
);

   localparam int unsigned PROD_W  = DATA_WIDTH + LO_WIDTH;
   localparam int unsigned SUM_W   = PROD_W + 1;
   // One guard bit above the sum so adding the rounding constant cannot wrap.
   localparam int unsigned EXT_W   = SUM_W + 1;
   localparam int unsigned SMAX    = SUM_W - 1;
   localparam int unsigned S_EFF_W = $clog2(SUM_W);

   // Scale, round and saturate one sum. Returns {saturated, value}.
   function automatic logic [OUT_WIDTH:0] scale_sat(
      input logic signed [SUM_W-1:0]   sum,
      input logic signed [EXT_W-1:0]   rnd,
      input logic        [S_EFF_W-1:0] s
   );
      logic signed [EXT_W-1:0] ext;
      logic signed [EXT_W-1:0] r;
      logic signed [EXT_W-1:0] max_v;
      logic signed [EXT_W-1:0] min_v;
      max_v = {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
      min_v = {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
      ext   = EXT_W'(sum) + rnd;
      r     = ext >>> s;
      if (r > max_v) begin
         return {1'b1, max_v[OUT_WIDTH-1:0]};
      end else if (r < min_v) begin
         return {1'b1, min_v[OUT_WIDTH-1:0]};
      end
      return {1'b0, r[OUT_WIDTH-1:0]};
   endfunction

   // ------------------------------------------------------------------
   // Stage registers
   // ------------------------------------------------------------------
   logic                          v1_q, v2_q, v3_q;
   logic signed [DATA_WIDTH-1:0]  di1_q, dq1_q;
   logic signed [LO_WIDTH-1:0]    cos1_q, sin1_q;
   logic                          cm1_q, cm2_q;
   logic        [SHIFT_WIDTH-1:0] sh1_q, sh2_q, sh3_q;

   logic signed [PROD_W-1:0]      p_dc_d, p_ds_d, p_qc_d, p_qs_d;
   logic signed [PROD_W-1:0]      p_dc_q, p_ds_q, p_qc_q, p_qs_q;

   logic signed [SUM_W-1:0]       sum_i_d, sum_q_d;
   logic signed [SUM_W-1:0]       sum_i_q, sum_q_q;

   logic        [S_EFF_W-1:0]     s_eff;
   logic signed [EXT_W-1:0]       rnd;
   logic        [OUT_WIDTH:0]     res_i, res_q;
   logic                          sat_any;

   logic                          out_valid_q;
   logic signed [OUT_WIDTH-1:0]   i_out_q, q_out_q;
   logic                          ovf_d, ovf_q;

   // Stage valids: reset drops every in-flight sample.
   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else begin
         v1_q <= in_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
      end
   end

   // S1: capture the sample together with its own mode and shift.
   always_ff @(posedge clock) begin
      di1_q  <= data_i;
      dq1_q  <= data_q;
      cos1_q <= cosine_in;
      sin1_q <= sine_in;
      cm1_q  <= complex_mode;
      sh1_q  <= shift;
   end

   // S2 next-state: full-width signed products (no wrap at full scale).
   always_comb begin
      p_dc_d = PROD_W'(di1_q) * PROD_W'(cos1_q);
      p_ds_d = PROD_W'(di1_q) * PROD_W'(sin1_q);
      p_qc_d = PROD_W'(dq1_q) * PROD_W'(cos1_q);
      p_qs_d = PROD_W'(dq1_q) * PROD_W'(sin1_q);
   end

   // S2: register products, forward mode and shift.
   always_ff @(posedge clock) begin
      p_dc_q <= p_dc_d;
      p_ds_q <= p_ds_d;
      p_qc_q <= p_qc_d;
      p_qs_q <= p_qs_d;
      cm2_q  <= cm1_q;
      sh2_q  <= sh1_q;
   end

   // S3 next-state: real passes products through; complex multiplies by e^-jwt.
   always_comb begin
      sum_i_d = SUM_W'(p_dc_q);
      sum_q_d = SUM_W'(p_ds_q);
      if (cm2_q) begin
         sum_i_d = SUM_W'(p_dc_q) + SUM_W'(p_qs_q);
         sum_q_d = SUM_W'(p_qc_q) - SUM_W'(p_ds_q);
      end
   end

   // S3: register sums, forward shift.
   always_ff @(posedge clock) begin
      sum_i_q <= sum_i_d;
      sum_q_q <= sum_q_d;
      sh3_q   <= sh2_q;
   end

   // Effective shift, clamped so the whole sum can be shifted out at most.
   always_comb begin
      s_eff = S_EFF_W'(sh3_q);
      if (32'(sh3_q) > SMAX) begin
         s_eff = S_EFF_W'(SMAX);
      end
   end

`ifdef MIXER_IQ_DITHER_EN
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // LFSR next state: advance only when a valid sample is being scaled.
   always_comb begin
      lfsr_d = lfsr_q;
      if (v3_q) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   // LFSR register, reseeded on reset.
   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // Dither: low s bits of the LFSR, shared by I and Q; zero when s = 0.
   always_comb begin
      rnd = EXT_W'(lfsr_q) & ~({EXT_W{1'b1}} << s_eff);
   end
`else
   // Round half up: add half an LSB of the shifted result.
   always_comb begin
      rnd = '0;
      if (s_eff != '0) begin
         rnd = EXT_W'(1) << (s_eff - 1'b1);
      end
   end
`endif

   // S4 next-state: scale both rails and flag any saturation on a valid sample.
   always_comb begin
      res_i   = scale_sat(sum_i_q, rnd, s_eff);
      res_q   = scale_sat(sum_q_q, rnd, s_eff);
      sat_any = v3_q & (res_i[OUT_WIDTH] | res_q[OUT_WIDTH]);
      // Set has priority over clear.
      ovf_d   = ovf_q;
      if (sat_any) begin
         ovf_d = 1'b1;
      end else if (ovf_clear) begin
         ovf_d = 1'b0;
      end
   end

   // S4: outputs update only with a valid sample, otherwise hold.
   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         out_valid_q <= 1'b0;
         i_out_q     <= '0;
         q_out_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= v3_q;
         ovf_q       <= ovf_d;
         if (v3_q) begin
            i_out_q <= res_i[OUT_WIDTH-1:0];
            q_out_q <= res_q[OUT_WIDTH-1:0];
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign i_out      = i_out_q;
   assign q_out      = q_out_q;
   assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_mixer_iq_scaled.sv
// Self-checking bench for mixer_iq_scaled: directed cases plus randomized
// streaming against an arithmetic reference model with a 4-deep delay queue.
module tb_mixer_iq_scaled;

   localparam int unsigned DW = 12;
   localparam int unsigned LW = 12;
   localparam int unsigned OW = 16;
   localparam int unsigned SW = 5;

   logic                  clock = 1'b0;
   logic                  clock_sreset;
   logic                  in_valid;
   logic signed [DW-1:0]  data_i, data_q;
   logic signed [LW-1:0]  cosine_in, sine_in;
   logic                  complex_mode;
   logic        [SW-1:0]  shift;
   logic                  ovf_clear;
   logic                  out_valid;
   logic signed [OW-1:0]  i_out, q_out;
   logic                  ovf_sticky;

   mixer_iq_scaled #(
      .DATA_WIDTH (DW),
      .LO_WIDTH   (LW),
      .OUT_WIDTH  (OW),
      .SHIFT_WIDTH(SW)
   ) dut (
      .clock       (clock),
      .clock_sreset(clock_sreset),
      .in_valid    (in_valid),
      .data_i      (data_i),
      .data_q      (data_q),
      .cosine_in   (cosine_in),
      .sine_in     (sine_in),
      .complex_mode(complex_mode),
      .shift       (shift),
      .ovf_clear   (ovf_clear),
      .out_valid   (out_valid),
      .i_out       (i_out),
      .q_out       (q_out),
      .ovf_sticky  (ovf_sticky)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit     v;
      longint i;
      longint q;
      bit     sat;
   } ent_t;

   ent_t   pipe[$];
   bit     exp_v   = 1'b0;
   longint exp_i   = 0;
   longint exp_q   = 0;
   bit     exp_ovf = 1'b0;

   // Arithmetic reference: floor((sum + half) / 2^s) with s clamped to 24.
   function automatic longint scale_ref(longint sum, int sh);
      longint s, d, num, r;
      s = (sh > 24) ? 24 : sh;
      if (s == 0) return sum;
      d   = longint'(1) << s;
      num = sum + d / 2;
      r   = num / d;
      if ((num % d != 0) && (num < 0)) r = r - 1;
      return r;
   endfunction

   function automatic longint clamp(longint r);
      if (r > 32767) return 32767;
      if (r < -32768) return -32768;
      return r;
   endfunction

   task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
   task automatic step(bit v, int di, int dq, int c, int sn, bit cm, int sh, bit clr, bit rst);
      ent_t   e, o;
      longint si, sq, ri, rq;
      in_valid     = v;
      data_i       = DW'(di);
      data_q       = DW'(dq);
      cosine_in    = LW'(c);
      sine_in      = LW'(sn);
      complex_mode = cm;
      shift        = SW'(sh);
      ovf_clear    = clr;
      clock_sreset = rst;
      if (cm) begin
         si = longint'(di) * c + longint'(dq) * sn;
         sq = longint'(dq) * c - longint'(di) * sn;
      end else begin
         si = longint'(di) * c;
         sq = longint'(di) * sn;
      end
      ri    = scale_ref(si, sh);
      rq    = scale_ref(sq, sh);
      e.v   = v && !rst;
      e.i   = clamp(ri);
      e.q   = clamp(rq);
      e.sat = (clamp(ri) != ri) || (clamp(rq) != rq);
      @(posedge clock);
      if (rst) begin
         pipe.delete();
         repeat (3) pipe.push_back('{v: 1'b0, i: 0, q: 0, sat: 1'b0});
      end
      pipe.push_back(e);
      o = pipe.pop_front();
      if (rst) begin
         exp_v = 1'b0; exp_i = 0; exp_q = 0; exp_ovf = 1'b0;
      end else begin
         exp_v = o.v;
         if (o.v) begin
            exp_i = o.i;
            exp_q = o.q;
         end
         if (o.v && o.sat) exp_ovf = 1'b1;
         else if (clr) exp_ovf = 1'b0;
      end
      #1;
      check("out_valid", {63'b0, out_valid}, {63'b0, exp_v});
      check("i_out", i_out, exp_i);
      check("q_out", q_out, exp_q);
      check("ovf_sticky", {63'b0, ovf_sticky}, {63'b0, exp_ovf});
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic int rnd_s12();
      if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) == 0) ? -2048 : 2047;
      return int'($urandom_range(0, 4095)) - 2048;
   endfunction

   initial begin
      pipe.delete();
      repeat (3) pipe.push_back('{v: 1'b0, i: 0, q: 0, sat: 1'b0});
`ifdef MIXER_IQ_DITHER_EN
      begin
         longint acc;
         int     nvalid;
         logic signed [OW-1:0] first;
         step(0, 0, 0, 0, 0, 0, 0, 0, 1);
         step(0, 0, 0, 0, 0, 0, 0, 0, 1);
         acc = 0; nvalid = 0;
         in_valid = 1; data_i = 12'sd100; data_q = 0; cosine_in = 12'sd2047;
         sine_in = 0; complex_mode = 0; shift = 5'd4; ovf_clear = 0; clock_sreset = 0;
         for (int k = 0; k < 4096 + 3; k++) begin
            if (k == 4096) in_valid = 0;
            @(posedge clock); #1;
            if (out_valid) begin
               nvalid++;
               acc += i_out;
               check("dither_range", {63'b0, (i_out == 16'sd12793) || (i_out == 16'sd12794)}, 1);
            end
         end
         @(posedge clock); #1;
         if (out_valid) begin
            nvalid++; acc += i_out;
         end
         check("dither_count", nvalid, 4096);
         check("dither_mean", {63'b0, (acc * 100 - 4096 * 64'sd1279375 <= 4096) &&
                                      (acc * 100 - 4096 * 64'sd1279375 >= -4096)}, 1);
         in_valid = 1; shift = 5'd0;
         repeat (3) @(posedge clock);
         for (int k = 0; k < 16; k++) begin
            @(posedge clock); #1;
            check("dither_s0_const", i_out, 32767);
         end
         in_valid = 0;
      end
`else
      // Reset state
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 5, 5, 5, 5, 0, 0, 0, 1);
      check("reset_valid", {63'b0, out_valid}, 0);
      check("reset_i", i_out, 0);
      check("reset_ovf", {63'b0, ovf_sticky}, 0);

      // Real mode, shift 4
      step(1, 100, 0, 2047, 0, 0, 4, 0, 0);
      idle(2);
      check("t1_early_valid", {63'b0, out_valid}, 0);
      idle(1);
      check("t1_valid", {63'b0, out_valid}, 1);
      check("t1_i", i_out, 12794);
      check("t1_q", q_out, 0);
      check("t1_ovf", {63'b0, ovf_sticky}, 0);

      // Saturation, sticky flag, clear, set-over-clear
      step(1, 100, 0, 2047, 0, 0, 0, 0, 0);
      idle(3);
      check("t2_i_sat", i_out, 32767);
      check("t2_ovf_set", {63'b0, ovf_sticky}, 1);
      idle(1);
      check("t2_i_hold", i_out, 32767);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("t2_ovf_clr", {63'b0, ovf_sticky}, 0);
      step(1, 100, 0, 2047, 0, 0, 0, 0, 0);
      idle(2);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("t2_set_wins", {63'b0, ovf_sticky}, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);

      // Complex mode
      step(1, 1000, 0, 0, 1000, 1, 5, 0, 0);
      idle(3);
      check("t3_i", i_out, 0);
      check("t3_q", q_out, -31250);

      // Full-scale corner
      step(1, -2048, -2048, -2048, -2048, 1, 0, 0, 0);
      step(1, -2048, -2048, -2048, -2048, 1, 11, 0, 0);
      idle(2);
      check("t4_i_sat", i_out, 32767);
      check("t4_q_sat", q_out, 0);
      idle(1);
      check("t4_i_s11", i_out, 4096);
      check("t4_q_s11", q_out, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);

      // Streaming with gaps, per-sample shift
      begin
         logic [19:0] pat;
         pat = 20'b1101001101100111_0101;
         for (int k = 0; k < 20; k++)
            step(pat[19-k], rnd_s12(), rnd_s12(), rnd_s12(), rnd_s12(),
                 1'($urandom_range(0, 1)), (k * 7) % 32, 0, 0);
      end
      idle(4);

      // Reset mid-stream drops in-flight samples
      for (int k = 0; k < 6; k++)
         step(1, rnd_s12(), rnd_s12(), rnd_s12(), rnd_s12(), 1, 8, 0, 0);
      step(1, 777, 1, 2, 3, 1, 8, 0, 1);
      for (int k = 0; k < 3; k++) begin
         step(1, rnd_s12(), rnd_s12(), rnd_s12(), rnd_s12(), 1, 8, 0, 0);
         check("rst_no_stale", {63'b0, out_valid}, 0);
      end
      step(1, rnd_s12(), rnd_s12(), rnd_s12(), rnd_s12(), 1, 8, 0, 0);
      check("rst_first_valid", {63'b0, out_valid}, 1);

      // Randomized traffic
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 9) < 7, rnd_s12(), rnd_s12(), rnd_s12(), rnd_s12(),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
              $urandom_range(0, 9) == 0, 0);
      idle(4);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mixer_iq_scaled.md
Name: mixer_iq_scaled

Overview:
Parametrised quadrature mixer that multiplies real or complex samples by an NCO cosine/sine pair. Outputs are scaled by a run-time arithmetic right shift with rounding and saturation, and carry a valid strobe. Sits between the ADC/decimator front end and the CIC/FIR chain, and replaces the fixed-width, truncating, strobe-less mixer. Fully pipelined, one sample per clock, no backpressure.

Parameters:
DATA_WIDTH, 12, width of signed data_i/data_q
LO_WIDTH, 12, width of signed cosine_in/sine_in
OUT_WIDTH, 16, width of signed i_out/q_out
SHIFT_WIDTH, 5, width of shift control
Derived: PROD_W = DATA_WIDTH+LO_WIDTH; SUM_W = PROD_W+1

Ports:
clock  in  1  system clock
clock_sreset  in  1  synchronous active-high reset
in_valid  in  1  input sample qualifier
data_i  in  DATA_WIDTH  signed in-phase or real input
data_q  in  DATA_WIDTH  signed quadrature input, ignored when complex_mode=0
cosine_in  in  LO_WIDTH  signed NCO cosine
sine_in  in  LO_WIDTH  signed NCO sine
complex_mode  in  1  0 = real input, 1 = complex input
shift  in  SHIFT_WIDTH  right-shift amount applied to the sum
ovf_clear  in  1  clears the sticky overflow flag
out_valid  out  1  output sample qualifier
i_out  out  OUT_WIDTH  signed I result
q_out  out  OUT_WIDTH  signed Q result
ovf_sticky  out  1  set on any saturation event

Behaviour:
- Reset: out_valid=0, i_out=0, q_out=0, ovf_sticky=0, all stage valids=0; LFSR reseeded (see Optional Feature).
- Reset mid-operation drops every in-flight sample. First out_valid after reset follows the first in_valid sampled with reset low by exactly 4 cycles.
- Pipeline, fixed latency 4:
  - S1: register data_i, data_q, cosine_in, sine_in, complex_mode, shift. shift and complex_mode travel with their sample, so changing them never corrupts in-flight data.
  - S2: four signed PROD_W products: di*cos, di*sin, dq*cos, dq*sin.
  - S3: SUM_W sums.
    - real mode: I = di*cos, Q = di*sin (sign-extended).
    - complex mode: I = di*cos + dq*sin, Q = dq*cos - di*sin, i.e. multiply by e^-jwt.
  - S4: scale, round, saturate, register the outputs.
- Scaling:
  - Effective shift s = min(shift, SUM_W-1).
  - r = (sum + round_const) >>> s, where round_const = 0 if s=0, else 1<<(s-1) (round half up toward +inf). Compute in SUM_W+1 bits, so no internal wrap.
  - If r > 2^(OUT_WIDTH-1)-1, output the max positive value; if r < -2^(OUT_WIDTH-1), output the min negative value.
  - I and Q saturate independently.
- Valid handling:
  - out_valid = in_valid delayed 4 cycles.
  - i_out/q_out update only on cycles where out_valid=1; otherwise they hold their last value.
  - Gaps in in_valid produce matching gaps in out_valid; no samples are reordered or merged.
- ovf_sticky:
  - Set the cycle after any S4 valid sample saturates on I or Q.
  - ovf_clear=1 clears it the next cycle.
  - Simultaneous set and clear: set wins.
- Full-scale corner: di=-2^(DATA_WIDTH-1) with cos=-2^(LO_WIDTH-1) must produce the exact positive product with no wrap.

Optional Feature:
- Macro MIXER_IQ_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on reset, advances once per S4 valid sample.
  - round_const is replaced by the LFSR's low s bits, zero-extended; the same value is used for I and Q.
  - When s=0, no dither is applied.
- Undefined: no LFSR is present; deterministic round-half-up as above.
- All directed tests below assume the macro is undefined, except the dither check.

Test Plan:
1. Real mode, di=100, cos=2047, sin=0, shift=4, one valid pulse -> 4 cycles later out_valid=1, i_out=12794, q_out=0, ovf_sticky=0.
2. Real mode, same data, shift=0 -> i_out=32767 (saturated); ovf_sticky=1 the following cycle. Then ovf_clear=1 for one cycle -> ovf_sticky=0. Then ovf_clear asserted the same cycle as a new saturation -> ovf_sticky stays 1.
3. Complex mode, di=1000, dq=0, cos=0, sin=1000, shift=5 -> i_out=0, q_out=-31250.
4. Complex mode, di=dq=-2048, cos=sin=-2048, shift=0 -> i_out=32767 (sum 8388608 saturated), q_out=0. With shift=11: i_out=4096, q_out=0.
5. Streaming 20 samples with in_valid toggling 1,1,0,1,0,0,1..., shift changing every sample -> out_valid pattern equals in_valid delayed 4, each output uses its own shift. Assert clock_sreset mid-stream -> out_valid=0 for 4 cycles after release; no stale sample emitted.
6. With MIXER_IQ_DITHER_EN: constant input sum=204700, shift=4 over 4096 samples -> every i_out is 12793 or 12794, mean within ±0.01 of 12793.75. With shift=0 -> i_out constant.
